// File: rtl/mem8x8_arbiter.sv
// Two-port round-robin arbiter in front of an 8x8 byte array.
// Each transaction runs IDLE -> SETUP -> STROBE -> DONE with op/data held around a single-cycle select.
module mem8x8_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic       op_a,
  input  logic [2:0] addr_a,
  input  logic [7:0] wdata_a,
  output logic       ack_a,
  output logic [7:0] rdata_a,
  input  logic       req_b,
  input  logic       op_b,
  input  logic [2:0] addr_b,
  input  logic [7:0] wdata_b,
  output logic       ack_b,
  output logic [7:0] rdata_b,
  output logic [7:0] mem_sel,
  output logic       mem_op,
  output logic [7:0] mem_inp,
  input  logic [7:0] mem_outp,
  output logic       busy,
  output logic       grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       load;
  logic       sel_en;
  logic       win;
  logic       op_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q;
  logic       grant_q;
  logic       last_grant;

  // A lone requester wins; on a tie the port that did not win last time goes.
  assign win = (req_a && req_b) ? ~last_grant : req_b;

  // NOTE: state and every other register are updated with <= so all flops
  // sample the same pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    sel_en     = 1'b0;
    ack_a      = 1'b0;
    ack_b      = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req_a || req_b) begin
          load       = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP:  state_next = STROBE;
      STROBE: begin
        sel_en     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ack_a      = ~grant_q;
        ack_b      = grant_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command registers only load on IDLE -> SETUP, which keeps op/data stable
  // for a full cycle on each side of the select pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      rdata_a    <= '0;
      rdata_b    <= '0;
    end else begin
      if (load) begin
        grant_q <= win;
        op_q    <= win ? op_b    : op_a;
        addr_q  <= win ? addr_b  : addr_a;
        wdata_q <= win ? wdata_b : wdata_a;
      end
      if (state == STROBE && !op_q) begin
        if (grant_q) rdata_b <= mem_outp;
        else         rdata_a <= mem_outp;
      end
      if (state == DONE) last_grant <= grant_q;
    end
  end

  assign mem_sel = sel_en ? (8'b1 << addr_q) : 8'b0;
  assign mem_op  = op_q;
  assign mem_inp = wdata_q;
  assign grant   = grant_q;

endmodule

// File: tb/tb_mem8x8_arbiter.sv
// Self-checking bench for mem8x8_arbiter: behavioural array, transaction-level
// reference model, directed vector table, corner sequences and random traffic.
module tb_mem8x8_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, op_a, req_b, op_b;
  logic [2:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       ack_a, ack_b;
  logic [7:0] rdata_a, rdata_b;
  logic [7:0] mem_sel;
  logic       mem_op;
  logic [7:0] mem_inp;
  logic [7:0] mem_outp;
  logic       busy, grant;

  always #5 clk = ~clk;

  mem8x8_arbiter dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .op_a(op_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .op_b(op_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .mem_sel(mem_sel), .mem_op(mem_op), .mem_inp(mem_inp), .mem_outp(mem_outp),
    .busy(busy), .grant(grant)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural 8x8 array: read data only while a byte is selected for read.
  logic [7:0] env_mem [8] = '{default: 8'h00};

  function automatic int sel_idx(input logic [7:0] s);
    for (int i = 0; i < 8; i++) if (s[i]) return i;
    return 0;
  endfunction

  assign mem_outp = (mem_sel != 8'h00 && !mem_op) ? env_mem[sel_idx(mem_sel)] : 8'hEE;

  always @(posedge clk)
    if (mem_sel != 8'h00 && mem_op) env_mem[sel_idx(mem_sel)] <= mem_inp;

  // Reference model: a request seen while the arbiter is free is granted by
  // round-robin, completes two edges later, and the arbiter is free again four edges after the grant.
  int         cyc = 0;
  int         next_free = 0;
  bit         last_g = 1'b1;
  logic [7:0] mdl_mem [8] = '{default: 8'h00};
  logic [7:0] mdl_rd [2] = '{default: 8'h00};
  bit         pend_v = 1'b0;
  int         pend_cyc;
  bit         pend_port, pend_op;
  logic [2:0] pend_addr;
  logic [7:0] pend_wdata;
  bit         rst_edge = 1'b0;

  always @(posedge clk) begin
    cyc++;
    rst_edge = reset;
    if (reset) begin
      pend_v    = 1'b0;
      next_free = cyc + 1;
      last_g    = 1'b1;
      mdl_rd[0] = 8'h00;
      mdl_rd[1] = 8'h00;
    end else if (cyc >= next_free && (req_a || req_b)) begin
      pend_port  = (req_a && req_b) ? !last_g : req_b;
      pend_op    = pend_port ? op_b    : op_a;
      pend_addr  = pend_port ? addr_b  : addr_a;
      pend_wdata = pend_port ? wdata_b : wdata_a;
      pend_v     = 1'b1;
      pend_cyc   = cyc + 2;
      next_free  = cyc + 4;
    end
  end

  logic [7:0] prev_sel = 8'h00;
  logic       prev_op = 1'b0;
  logic [7:0] prev_inp = 8'h00;

  always @(negedge clk) begin
    bit due;
    due = pend_v && (pend_cyc == cyc);
    if (due) begin
      if (pend_op) mdl_mem[pend_addr] = pend_wdata;
      else         mdl_rd[pend_port]  = mdl_mem[pend_addr];
      last_g = pend_port;
      pend_v = 1'b0;
    end
    check("ack_a", ack_a, due && !pend_port);
    check("ack_b", ack_b, due && pend_port);
    if (due || ack_a || ack_b) begin
      check("rdata_a", rdata_a, mdl_rd[0]);
      check("rdata_b", rdata_b, mdl_rd[1]);
    end
    if (due) check("grant", grant, pend_port);
    if (mem_sel != 8'h00) begin
      check("sel_onehot", $onehot(mem_sel), 1);
      check("cmd_stable_before_sel", {mem_op, mem_inp}, {prev_op, prev_inp});
    end
    if (prev_sel != 8'h00 && !rst_edge)
      check("cmd_stable_after_sel", {mem_op, mem_inp}, {prev_op, prev_inp});
    prev_sel = mem_sel;
    prev_op  = mem_op;
    prev_inp = mem_inp;
  end

  // Starts one transaction at the current falling edge and waits for its ack.
  task automatic do_txn(input bit port, input bit op, input logic [2:0] addr,
                        input logic [7:0] wdata, output int lat,
                        output logic [7:0] sel_seen, output int sel_cycles);
    if (port) begin req_b = 1'b1; op_b = op; addr_b = addr; wdata_b = wdata; end
    else      begin req_a = 1'b1; op_a = op; addr_a = addr; wdata_a = wdata; end
    lat = 0; sel_seen = 8'h00; sel_cycles = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_sel != 8'h00) begin sel_seen = mem_sel; sel_cycles++; end
    end while (!(port ? ack_b : ack_a) && lat < 20);
    if (port) req_b = 1'b0;
    else      req_a = 1'b0;
  endtask

  typedef struct {
    bit         port;
    bit         op;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_sel;
    logic [7:0] exp_rd;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [$];
    int         lat, sc;
    logic [7:0] ss;
    bit         who [$];
    int         when [$];

    reset = 1'b1;
    req_a = 1'b0; op_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; op_b = 1'b0; addr_b = '0; wdata_b = '0;

    tbl.push_back('{0, 1, 3'd3, 8'hA5, 8'h08, 8'h00});
    tbl.push_back('{0, 0, 3'd3, 8'h00, 8'h08, 8'hA5});
    tbl.push_back('{1, 1, 3'd7, 8'h3C, 8'h80, 8'h00});
    tbl.push_back('{0, 1, 3'd0, 8'hFF, 8'h01, 8'h00});
    tbl.push_back('{0, 0, 3'd0, 8'h00, 8'h01, 8'hFF});
    tbl.push_back('{1, 0, 3'd7, 8'h00, 8'h80, 8'h3C});
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pat;
      logic [7:0] sel;
      pat = 8'(i * 17);
      sel = 8'(1 << i);
      tbl.push_back('{i[0], 1, 3'(i), pat, sel, 8'h00});
      tbl.push_back('{!i[0], 0, 3'(i), 8'h00, sel, pat});
    end

    repeat (2) @(negedge clk);
    check("rst_mem_sel", mem_sel, 8'h00);
    check("rst_mem_op", mem_op, 1'b0);
    check("rst_mem_inp", mem_inp, 8'h00);
    check("rst_acks", {ack_a, ack_b}, 2'b00);
    check("rst_rdata", {rdata_a, rdata_b}, 16'h0000);
    check("rst_busy_grant", {busy, grant}, 2'b00);
    reset = 1'b0;

    foreach (tbl[k]) begin
      do_txn(tbl[k].port, tbl[k].op, tbl[k].addr, tbl[k].wdata, lat, ss, sc);
      check("latency", lat, 3);
      check("sel_value", ss, tbl[k].exp_sel);
      check("sel_cycles", sc, 1);
      if (!tbl[k].op)
        check("readback", tbl[k].port ? rdata_b : rdata_a, tbl[k].exp_rd);
      @(negedge clk);
    end
    // Memory now holds addr*0x11 in every byte.

    // Both ports requesting from reset release: A, B, A, B, four cycles apart.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_a = 1'b1; op_a = 1'b0; addr_a = 3'd3;
    req_b = 1'b1; op_b = 1'b0; addr_b = 3'd7;
    for (int t = 0; t < 40 && who.size() < 4; t++) begin
      @(negedge clk);
      if (ack_a) begin who.push_back(1'b0); when.push_back(t); end
      if (ack_b) begin who.push_back(1'b1); when.push_back(t); end
    end
    req_a = 1'b0; req_b = 1'b0;
    check("rr_ack_count", who.size(), 4);
    for (int k = 0; k < who.size(); k++) begin
      check("rr_order", who[k], k % 2);
      if (k > 0) check("rr_spacing", when[k] - when[k-1], 4);
    end
    check("rr_rdata_a", rdata_a, 8'h33);
    check("rr_rdata_b", rdata_b, 8'h77);
    @(negedge clk);

    // Reset during STROBE aborts the read with no ack.
    req_a = 1'b1; op_a = 1'b0; addr_a = 3'd2;
    repeat (2) @(negedge clk);
    check("abort_strobe_sel", mem_sel, 8'h04);
    reset = 1'b1;
    @(negedge clk);
    check("abort_sel", mem_sel, 8'h00);
    check("abort_busy", busy, 1'b0);
    check("abort_ack", ack_a, 1'b0);
    reset = 1'b0; req_a = 1'b0;
    @(negedge clk);
    do_txn(1'b0, 1'b0, 3'd2, 8'h00, lat, ss, sc);
    check("post_abort_latency", lat, 3);
    check("post_abort_rdata", rdata_a, 8'h22);
    @(negedge clk);

    // Random traffic; requests hold until acked, sometimes re-requesting at once.
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (ack_a) begin
        if ($urandom_range(3) == 0) begin
          op_a = 1'($urandom_range(1)); addr_a = 3'($urandom); wdata_a = 8'($urandom);
        end else req_a = 1'b0;
      end else if (!req_a && $urandom_range(2) == 0) begin
        req_a = 1'b1; op_a = 1'($urandom_range(1)); addr_a = 3'($urandom); wdata_a = 8'($urandom);
      end
      if (ack_b) begin
        if ($urandom_range(3) == 0) begin
          op_b = 1'($urandom_range(1)); addr_b = 3'($urandom); wdata_b = 8'($urandom);
        end else req_b = 1'b0;
      end else if (!req_b && $urandom_range(2) == 0) begin
        req_b = 1'b1; op_b = 1'($urandom_range(1)); addr_b = 3'($urandom); wdata_b = 8'($urandom);
      end
    end
    for (int t = 0; t < 40 && (req_a || req_b); t++) begin
      @(negedge clk);
      if (ack_a) req_a = 1'b0;
      if (ack_b) req_b = 1'b0;
    end
    check("drain", {req_a, req_b}, 2'b00);
    repeat (2) @(negedge clk);
    check("idle_at_end", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
